// File: rtl/multi_gate_filtered_pkg.sv
// Shared gate operation codes and elaboration-time helpers for multi_gate_filtered.
package multi_gate_filtered_pkg;

  // Reduction operator selected by the mode input.
  typedef enum logic [1:0] {
    GATE_AND  = 2'b00,
    GATE_OR   = 2'b01,
    GATE_XOR  = 2'b10,
    GATE_NAND = 2'b11
  } gate_mode_e;

  // Ceiling log2, used only for sizing at elaboration.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'(1) << i) < 64'(v)) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/multi_gate_filtered_chan_debounce.sv
// One-bit synchroniser plus glitch filter: a new level is accepted only after
// FILT_CYCLES consecutive synchronised samples disagree with the held level.
module multi_gate_filtered_chan_debounce
  import multi_gate_filtered_pkg::*;
#(
  parameter int unsigned FILT_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic filt
);

  localparam int unsigned            CNT_W   = clog2(FILT_CYCLES) + 1;
  localparam logic [CNT_W-1:0]       CNT_MAX = CNT_W'(FILT_CYCLES - 1);

  logic             s1;
  logic             s2;
  logic [CNT_W-1:0] cnt;

  // Two-flop synchroniser followed by the consecutive-disagreement counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1   <= 1'b0;
      s2   <= 1'b0;
      cnt  <= '0;
      filt <= 1'b0;
    end else begin
      s1 <= raw;
      s2 <= s1;
      if (s2 == filt) begin
        cnt <= '0;
      end else if (cnt == CNT_MAX) begin
        filt <= s2;
        cnt  <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/multi_gate_filtered.sv
// Registered multi-input gate over debounced channels with a change pulse.
module multi_gate_filtered
  import multi_gate_filtered_pkg::*;
#(
  parameter int unsigned CHANNELS    = 4,
  parameter int unsigned FILT_CYCLES = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CHANNELS-1:0] in_bits,
  input  logic [CHANNELS-1:0] chan_en,
  input  logic [1:0]          mode,
  output logic                gate_out,
  output logic                change,
  output logic [CHANNELS-1:0] filt_bits
);

  logic                primed;
  logic                next_out_c;
  logic [CHANNELS-1:0] and_view_c;
  logic [CHANNELS-1:0] or_view_c;

  // One debounced filter per channel.
  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    multi_gate_filtered_chan_debounce #(
      .FILT_CYCLES(FILT_CYCLES)
    ) u_deb (
      .clk  (clk),
      .rst  (rst),
      .raw  (in_bits[i]),
      .filt (filt_bits[i])
    );
  end

  // Masked channels take the identity of the selected operator.
  always_comb begin
    and_view_c = filt_bits | ~chan_en;
    or_view_c  = filt_bits & chan_en;
    next_out_c = 1'b0;
    case (mode)
      GATE_AND:  next_out_c = &and_view_c;
      GATE_OR:   next_out_c = |or_view_c;
      GATE_XOR:  next_out_c = ^or_view_c;
      GATE_NAND: next_out_c = ~(&and_view_c);
      default:   next_out_c = 1'b0;
    endcase
  end

  // Output register; the first evaluation after reset never pulses change.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gate_out <= 1'b0;
      change   <= 1'b0;
      primed   <= 1'b0;
    end else begin
      gate_out <= next_out_c;
      change   <= primed & (next_out_c != gate_out);
      primed   <= 1'b1;
    end
  end

endmodule

// File: tb/tb_multi_gate_filtered.sv
// Self-checking bench: hand-derived vector tables, corner-case sequences and
// randomized traffic against a sample-window reference model.
module tb_multi_gate_filtered;
  import multi_gate_filtered_pkg::*;

  localparam int unsigned CH = 4;
  localparam int unsigned FC = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [CH-1:0] in_bits = '0;
  logic [CH-1:0] chan_en = '1;
  logic [1:0]    mode = GATE_AND;
  logic          gate_out;
  logic          change;
  logic [CH-1:0] filt_bits;

  always #5 clk = ~clk;

  multi_gate_filtered #(.CHANNELS(CH), .FILT_CYCLES(FC)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_bits   (in_bits),
    .chan_en   (chan_en),
    .mode      (mode),
    .gate_out  (gate_out),
    .change    (change),
    .filt_bits (filt_bits)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [CH-1:0] m_s1, m_s2, m_filt;
  logic          m_gate, m_change, m_primed;
  logic [CH-1:0] m_hist[$];   // most recent synchronised sample first

  function automatic logic ref_gate(input logic [CH-1:0] f, input logic [CH-1:0] en,
                                    input logic [1:0] md);
    int ones, active;
    ones = 0;
    active = 0;
    for (int c = 0; c < int'(CH); c++) begin
      if (en[c]) begin
        active++;
        if (f[c]) ones++;
      end
    end
    case (md)
      2'b00:   return ones == active;
      2'b01:   return ones > 0;
      2'b10:   return (ones % 2) == 1;
      default: return ones != active;
    endcase
  endfunction

  task automatic model_reset();
    m_s1 = '0; m_s2 = '0; m_filt = '0;
    m_gate = 1'b0; m_change = 1'b0; m_primed = 1'b0;
    m_hist.delete();
  endtask

  // A channel adopts a new level once its last FC samples all disagree with it.
  task automatic model_edge();
    logic [CH-1:0] sample;
    logic          nxt;
    logic          all_diff;
    sample   = m_s2;
    nxt      = ref_gate(m_filt, chan_en, mode);
    m_change = m_primed && (nxt != m_gate);
    m_gate   = nxt;
    m_primed = 1'b1;
    m_hist.push_front(sample);
    if (m_hist.size() > int'(FC)) void'(m_hist.pop_back());
    if (m_hist.size() == int'(FC)) begin
      for (int c = 0; c < int'(CH); c++) begin
        all_diff = 1'b1;
        for (int k = 0; k < int'(FC); k++) if (m_hist[k][c] == m_filt[c]) all_diff = 1'b0;
        if (all_diff) m_filt[c] = ~m_filt[c];
      end
    end
    m_s2 = m_s1;
    m_s1 = in_bits;
  endtask

  // One clock edge; outputs sampled 1 time unit after the edge.
  task automatic step(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check({tag, ".gate"},   32'(gate_out),  32'(m_gate));
    check({tag, ".change"}, 32'(change),    32'(m_change));
    check({tag, ".filt"},   32'(filt_bits), 32'(m_filt));
  endtask

  // Asynchronous reset asserted mid-cycle; outputs must clear before any edge.
  task automatic apply_reset(input string tag);
    rst = 1'b1;
    #1;
    model_reset();
    check({tag, ".rst_gate"},   32'(gate_out),  32'd0);
    check({tag, ".rst_change"}, 32'(change),    32'd0);
    check({tag, ".rst_filt"},   32'(filt_bits), 32'd0);
    #2;
    rst = 1'b0;
  endtask

  // ---------------- vector tables ----------------
  typedef struct {
    logic [CH-1:0] in_b;
    logic [CH-1:0] en;
    logic [1:0]    md;
    logic          exp_gate;
    logic          exp_change;
    logic [CH-1:0] exp_filt;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic [CH-1:0] i_b, input logic [CH-1:0] en, input logic [1:0] md,
                     input logic g, input logic ch, input logic [CH-1:0] f);
    vec_t v;
    v.in_b = i_b; v.en = en; v.md = md;
    v.exp_gate = g; v.exp_change = ch; v.exp_filt = f;
    tbl.push_back(v);
  endtask

  task automatic run_table(input string tag);
    foreach (tbl[i]) begin
      in_bits = tbl[i].in_b;
      chan_en = tbl[i].en;
      mode    = tbl[i].md;
      step(tag);
      check($sformatf("%s[%0d].gate", tag, i),   32'(gate_out),  32'(tbl[i].exp_gate));
      check($sformatf("%s[%0d].change", tag, i), 32'(change),    32'(tbl[i].exp_change));
      check($sformatf("%s[%0d].filt", tag, i),   32'(filt_bits), 32'(tbl[i].exp_filt));
    end
    tbl.delete();
  endtask

  initial begin
    int f_idx, g_idx, p_idx, pulses;

    // Power-on reset.
    #12;
    model_reset();
    check("por.gate",   32'(gate_out),  32'd0);
    check("por.change", 32'(change),    32'd0);
    check("por.filt",   32'(filt_bits), 32'd0);
    #2;
    rst = 1'b0;

    // 1: all ones applied before edge 0 -> filt at edge 5, gate/change at edge 6.
    for (int i = 0; i < 8; i++)
      add(4'hF, 4'hF, GATE_AND, i >= 6, i == 6, (i >= 5) ? 4'hF : 4'h0);
    run_table("t1");

    // 2: 3-sample glitch rejected, then a held low accepted.
    for (int i = 0; i < 3; i++) add(4'hB, 4'hF, GATE_AND, 1'b1, 1'b0, 4'hF);
    for (int i = 0; i < 8; i++) add(4'hF, 4'hF, GATE_AND, 1'b1, 1'b0, 4'hF);
    for (int i = 0; i < 8; i++)
      add(4'hB, 4'hF, GATE_AND, i < 6, i == 6, (i >= 5) ? 4'hB : 4'hF);
    run_table("t2");

    // 3: settle 0101 then step through the operators.
    in_bits = 4'h5; mode = GATE_AND;
    for (int i = 0; i < 10; i++) step("t3.settle");
    add(4'h5, 4'hF, GATE_OR,   1'b1, 1'b1, 4'h5);
    add(4'h5, 4'hF, GATE_OR,   1'b1, 1'b0, 4'h5);
    add(4'h5, 4'hF, GATE_XOR,  1'b0, 1'b1, 4'h5);
    add(4'h5, 4'hF, GATE_XOR,  1'b0, 1'b0, 4'h5);
    add(4'h5, 4'hF, GATE_NAND, 1'b1, 1'b1, 4'h5);
    add(4'h5, 4'hF, GATE_NAND, 1'b1, 1'b0, 4'h5);
    run_table("t3");

    // 4: all channels masked right after reset; first evaluation never pulses.
    in_bits = 4'h0; chan_en = 4'h0; mode = GATE_AND;
    @(posedge clk); #1;
    apply_reset("t4");
    add(4'h0, 4'h0, GATE_AND, 1'b1, 1'b0, 4'h0);
    add(4'h0, 4'h0, GATE_AND, 1'b1, 1'b0, 4'h0);
    add(4'h0, 4'h0, GATE_OR,  1'b0, 1'b1, 4'h0);
    add(4'h0, 4'h0, GATE_OR,  1'b0, 1'b0, 4'h0);
    run_table("t4");

    // 5: reset with a count in flight; full latency needed afterwards.
    chan_en = 4'hF; mode = GATE_NAND; in_bits = 4'h0;
    for (int i = 0; i < 3; i++) step("t5.settle");
    in_bits = 4'hF;
    for (int i = 0; i < 4; i++) step("t5.pending");
    check("t5.pre_gate", 32'(gate_out), 32'd1);
    apply_reset("t5");
    f_idx = -1; g_idx = -1;
    for (int i = 0; i < 20 && g_idx < 0; i++) begin
      step("t5.post");
      if (f_idx < 0 && filt_bits == 4'hF) f_idx = i;
      if (g_idx < 0 && gate_out == 1'b0) g_idx = i;
    end
    check("t5.filt_latency", 32'(f_idx), 32'd5);
    check("t5.gate_latency", 32'(g_idx), 32'd6);

    // 6: filter update and mode change land on the same evaluation.
    mode = GATE_XOR; in_bits = 4'h1;
    for (int i = 0; i < 10; i++) step("t6.settle");
    in_bits = 4'h3; pulses = 0;
    for (int i = 0; i < 10; i++) begin
      if (i == 6) mode = GATE_OR;
      step("t6a");
      if (change) pulses++;
    end
    check("t6a.pulses", 32'(pulses), 32'd0);
    check("t6a.gate",   32'(gate_out), 32'd1);
    check("t6a.filt",   32'(filt_bits), 32'h3);
    in_bits = 4'h0; pulses = 0; p_idx = -1;
    for (int i = 0; i < 10; i++) begin
      if (i == 6) mode = GATE_AND;
      step("t6b");
      if (change) begin
        pulses++;
        p_idx = i;
      end
    end
    check("t6b.pulses", 32'(pulses), 32'd1);
    check("t6b.pulse_edge", 32'(p_idx), 32'd6);

    // Randomized traffic against the reference model.
    for (int n = 0; n < 600; n++) begin
      for (int c = 0; c < int'(CH); c++)
        if ($urandom_range(0, 4) == 0) in_bits[c] = ~in_bits[c];
      if ($urandom_range(0, 11) == 0) mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 29) == 0) chan_en = CH'($urandom_range(0, 15));
      if ($urandom_range(0, 149) == 0) apply_reset("rnd");
      step("rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
